text_video_generator: RTL and testbench

//  Parametrised successor to the fixed VT52 raster: character-cell text video generator.
//  - Timing generics: porch, sync and total widths are parameters.
//  - Memory pipeline: explicit 2-stage fetch (char buffer, then font ROM), 1 ce_pixel each.
//  - New features: hardware scroll, per-cell reverse attribute, block/underline cursor.
//  - Placement: between char buffer / font ROM and the scaler/video mixer.

---
 rtl/text_video_generator_if.sv | 16 +
 rtl/text_video_generator.sv | 112 +++++++++++
 tb/tb_text_video_generator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/text_video_generator_if.sv
// text_video_generator_if: char buffer / font ROM fetch bus plus the raster output bundle
interface text_video_generator_if #(parameter int ADDR_BITS = 11);
  logic [ADDR_BITS-1:0] char_buffer_address;
  logic [7:0] char_buffer_data;
  logic [11:0] char_rom_address;
  logic [7:0] char_rom_data;
  logic hsync, vsync, hblank, vblank, video, frame_start;
  modport master(
    output char_buffer_address, char_rom_address, hsync, vsync, hblank, vblank, video, frame_start,
    input char_buffer_data, char_rom_data
  );
  modport slave(
    input char_buffer_address, char_rom_address, hsync, vsync, hblank, vblank, video, frame_start,
    output char_buffer_data, char_rom_data
  );
endinterface

// File: rtl/text_video_generator.sv
// text_video_generator: character-cell text raster with scroll, reverse attribute and cursor
module text_video_generator #(
  parameter int ROWS = 24,
  parameter int COLS = 80,
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7,
  parameter int ADDR_BITS = 11,
  parameter int H_VISIBLE = 640,
  parameter int H_BP = 96,
  parameter int H_FP = 104,
  parameter int H_SYNC = 96,
  parameter int V_BP = 16,
  parameter int V_SYNC = 2,
  parameter int V_TOTAL16 = 420,
  parameter int V_TOTAL8 = 262,
  parameter int ATTR_EN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pixel,
  input  logic font_8x8,
  input  logic [ROW_BITS-1:0] scroll_row,
  input  logic [COL_BITS-1:0] cursor_x,
  input  logic [ROW_BITS-1:0] cursor_y,
  input  logic cursor_blink_on,
  input  logic cursor_mode,
  text_video_generator_if.master bus
);
  localparam int H_TOTAL = H_BP + H_VISIBLE + H_FP + H_SYNC;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL16 > V_TOTAL8 ? V_TOTAL16 : V_TOTAL8);
  localparam logic [ROW_BITS:0] ROWS_W = ROWS;
  logic [HW-1:0] hc, hx;
  logic [VW-1:0] vc, vy, vt_m1;
  logic font_q, h_end, v_end, h_vis, v_vis, vis0, cur0;
  logic [ROW_BITS-1:0] scroll_q, row0, rs;
  logic [ROW_BITS:0] rs_sum;
  logic [COL_BITS-1:0] col0;
  logic [3:0] rowc0, rowc1;
  logic [2:0] colc0, colc1, colc2;
  logic [ADDR_BITS-1:0] addr0;
  logic [4:0] ctl0, ctl1, ctl2;
  logic vis1, vis2, cur1, cur2, rev2, font1;
  always_comb begin
    vt_m1 = font_q ? VW'(V_TOTAL8 - 1) : VW'(V_TOTAL16 - 1);
    h_end = hc == HW'(H_TOTAL - 1);
    v_end = vc == vt_m1;
    hx = hc - HW'(H_BP);
    vy = vc - VW'(V_BP);
    h_vis = hc >= HW'(H_BP) && hc < HW'(H_BP + H_VISIBLE);
    v_vis = vc >= VW'(V_BP) && vy < (font_q ? VW'(ROWS * 8) : VW'(ROWS * 16));
    vis0 = h_vis && v_vis;
    col0 = vis0 ? COL_BITS'(hx >> 3) : '0;
    row0 = vis0 ? ROW_BITS'(font_q ? (vy >> 3) : (vy >> 4)) : '0;
    rowc0 = font_q ? {1'b0, vy[2:0]} : vy[3:0];
    colc0 = hx[2:0];
    rs_sum = {1'b0, row0} + {1'b0, scroll_q};
    rs = rs_sum >= ROWS_W ? ROW_BITS'(rs_sum - ROWS_W) : ROW_BITS'(rs_sum);
    addr0 = ADDR_BITS'(int'(rs) * COLS + int'(col0));
    cur0 = cursor_blink_on && vis0 && col0 == cursor_x && row0 == cursor_y &&
           (!cursor_mode || rowc0 == (font_q ? 4'd7 : 4'd15));
    ctl0 = {hc < HW'(H_TOTAL - H_SYNC), vc <= vt_m1 - VW'(V_SYNC), !h_vis, !v_vis, hc == '0 && vc == '0};
  end
  // font and scroll only change at the frame wrap so a frame is never torn
  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
      font_q <= font_8x8;
      scroll_q <= scroll_row;
    end else if (ce_pixel) begin
      hc <= h_end ? '0 : hc + 1'b1;
      if (h_end) vc <= v_end ? '0 : vc + 1'b1;
      if (h_end && v_end) begin
        font_q <= font_8x8;
        scroll_q <= scroll_row;
      end
    end
  end
  // sync/blank ride the same three stages as the pixel so every pin lines up
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.char_buffer_address <= '0;
      bus.char_rom_address <= '0;
      ctl1 <= 5'b11110;
      ctl2 <= 5'b11110;
      {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.frame_start} <= 5'b11110;
      bus.video <= 1'b0;
      {vis1, vis2, cur1, cur2, rev2, font1} <= '0;
      rowc1 <= '0;
      colc1 <= '0;
      colc2 <= '0;
    end else if (ce_pixel) begin
      bus.char_buffer_address <= addr0;
      ctl1 <= ctl0;
      vis1 <= vis0;
      cur1 <= cur0;
      font1 <= font_q;
      rowc1 <= rowc0;
      colc1 <= colc0;
      bus.char_rom_address <= font1 ? 12'({1'b0, bus.char_buffer_data[6:0], rowc1[2:0]})
                                    : {bus.char_buffer_data, rowc1};
      rev2 <= ATTR_EN != 0 && font1 && bus.char_buffer_data[7];
      ctl2 <= ctl1;
      vis2 <= vis1;
      cur2 <= cur1;
      colc2 <= colc1;
      {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.frame_start} <= ctl2;
      bus.video <= vis2 && (bus.char_rom_data[~colc2] ^ rev2 ^ cur2);
    end
  end
endmodule

// File: tb/tb_text_video_generator.sv
// tb_text_video_generator: directed frame-level checks on a shrunken raster (44 x 56/32)
module tb_text_video_generator;
  localparam int HT = 44;
  localparam int FR16 = HT * 56;
  localparam int FR8 = HT * 32;
  logic clk = 0, reset = 1, ce_pixel = 1, font_8x8 = 0, cursor_blink_on = 0, cursor_mode = 0;
  logic [1:0] scroll_row = 0, cursor_y = 0;
  logic [2:0] cursor_x = 0;
  logic [7:0] cbuf [2048];
  logic [7:0] rom [4096];
  int n_checks = 0, n_fail = 0;
  bit halve = 0;
  int len, lit, vis_n, bad_lit, hs_low, vs_low, first_lit, first_vis, hold_err, n;
  logic vid_log [4096];
  logic hs_log [4096];
  logic vs_log [4096];
  logic [10:0] cba_log [4096];
  logic [11:0] rom_log [4096];
  text_video_generator_if #(.ADDR_BITS(11)) bus();
  text_video_generator #(
    .ROWS(3), .COLS(4), .ROW_BITS(2), .COL_BITS(3), .ADDR_BITS(11),
    .H_VISIBLE(32), .H_BP(4), .H_FP(4), .H_SYNC(4),
    .V_BP(2), .V_SYNC(2), .V_TOTAL16(56), .V_TOTAL8(32), .ATTR_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .font_8x8(font_8x8),
    .scroll_row(scroll_row), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_blink_on(cursor_blink_on), .cursor_mode(cursor_mode), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.char_buffer_data = cbuf[bus.char_buffer_address];
  assign bus.char_rom_data = rom[bus.char_rom_address];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [28:0] snap();
    return {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.video, bus.frame_start,
            bus.char_buffer_address, bus.char_rom_address};
  endfunction
  task automatic tick();
    logic [28:0] s;
    if (halve) begin
      ce_pixel = 1;
      @(posedge clk); #1;
      s = snap();
      ce_pixel = 0;
      @(posedge clk); #1;
      if (snap() !== s) hold_err++;
      ce_pixel = 1;
    end else begin
      @(posedge clk); #1;
    end
  endtask
  task automatic collect(input int t);
    vid_log[t] = bus.video;
    hs_log[t] = bus.hsync;
    vs_log[t] = bus.vsync;
    cba_log[t] = bus.char_buffer_address;
    rom_log[t] = bus.char_rom_address;
    if (!bus.hblank && !bus.vblank) begin
      vis_n++;
      if (first_vis < 0) first_vis = t;
    end
    if (bus.video) begin
      lit++;
      if (first_lit < 0) first_lit = t;
      if (bus.hblank || bus.vblank) bad_lit++;
    end
    if (!bus.hsync) hs_low++;
    if (!bus.vsync) vs_low++;
  endtask
  // starts on a frame_start sample, logs one frame, stops on the next frame_start
  task automatic run_frame(input int sw_t, input logic sw_font);
    {len, lit, vis_n, bad_lit, hs_low, vs_low} = '0;
    first_lit = -1;
    first_vis = -1;
    collect(0);
    for (int t = 1; t < 4000; t++) begin
      tick();
      if (t == sw_t) font_8x8 = sw_font;
      if (bus.frame_start) begin
        len = t;
        break;
      end
      collect(t);
    end
  endtask
  task automatic wait_fs(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.frame_start) begin
        cnt = i;
        break;
      end
    end
  endtask
  task automatic frame_basics(input string tag, input int exp_len, input int exp_vis);
    check({tag, "_len"}, len, exp_len);
    check({tag, "_vis"}, vis_n, exp_vis);
    check({tag, "_first_vis"}, first_vis, 92);
    check({tag, "_lit_in_blank"}, bad_lit, 0);
    check({tag, "_hs_low"}, hs_low, exp_len / HT * 4);
    check({tag, "_vs_low"}, vs_low, 88);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) cbuf[i] = 8'h41;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h80;
    repeat (3) tick();
    check("reset_out", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.video, bus.frame_start}, 6'b111100);
    check("reset_cba", bus.char_buffer_address, 0);
    check("reset_rom", bus.char_rom_address, 0);
    reset = 0;
    wait_fs(n);
    check("fs_latency", n, 3);
    run_frame(-1, 0);
    frame_basics("a16", FR16, 48 * 32);
    check("a_lit", lit, 192);
    check("a_first_lit", first_lit, 92);
    check("a_cell_px", {vid_log[92], vid_log[93], vid_log[100]}, 3'b101);
    check("a_hs_edge", {hs_log[39], hs_log[40]}, 2'b10);
    check("a_vs_edge", {vs_log[2375], vs_log[2376]}, 2'b10);
    check("a_rom16", rom_log[311], 12'h415);
    check("a_cba_r0c0", cba_log[90], 0);
    check("a_cba_r0c3", cba_log[114], 3);
    check("a_cba_r1c0", cba_log[794], 4);
    {cursor_x, cursor_y, cursor_blink_on, cursor_mode} = {3'd2, 2'd1, 1'b1, 1'b0};
    run_frame(-1, 0);
    check("cur_block_lit", lit, 288);
    check("cur_block_px", {vid_log[812], vid_log[813], vid_log[1472], vid_log[1473]}, 4'b0101);
    cursor_mode = 1;
    run_frame(-1, 0);
    check("cur_ul_lit", lit, 198);
    check("cur_ul_px", {vid_log[812], vid_log[813], vid_log[1472], vid_log[1473]}, 4'b1001);
    cursor_blink_on = 0;
    run_frame(-1, 0);
    check("cur_noblink_lit", lit, 192);
    {cursor_x, cursor_blink_on, cursor_mode} = {3'd5, 1'b1, 1'b0};
    run_frame(-1, 0);
    check("cur_outside_lit", lit, 192);
    cursor_blink_on = 0;
    scroll_row = 2;
    run_frame(-1, 0);
    check("scroll_held", cba_log[90], 0);
    scroll_row = 0;
    run_frame(-1, 0);
    check("scroll_r0c0", cba_log[90], 8);
    check("scroll_r0c3", cba_log[114], 11);
    check("scroll_r1c0", cba_log[794], 0);
    check("scroll_r2c0", cba_log[1498], 4);
    run_frame(1000, 1);
    check("font_switch_len", len, FR16);
    run_frame(-1, 1);
    frame_basics("i8", FR8, 24 * 32);
    check("i_lit", lit, 96);
    check("i_rom8", rom_log[311], 12'h20D);
    for (int i = 0; i < 2048; i++) cbuf[i] = 8'hC1;
    run_frame(-1, 1);
    check("rev_lit", lit, 672);
    check("rev_rom8", rom_log[311], 12'h20D);
    check("rev_px", {vid_log[92], vid_log[93]}, 2'b01);
    halve = 1;
    hold_err = 0;
    run_frame(-1, 1);
    halve = 0;
    check("half_len", len, FR8);
    check("half_lit", lit, 672);
    check("half_px", {vid_log[92], vid_log[93]}, 2'b01);
    check("half_hold", hold_err, 0);
    repeat (500) tick();
    reset = 1;
    tick();
    check("midreset_out", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.video, bus.frame_start}, 6'b111100);
    check("midreset_cba", bus.char_buffer_address, 0);
    reset = 0;
    wait_fs(n);
    check("midreset_fs", n, 3);
    run_frame(-1, 1);
    check("midreset_len", len, FR8);
    check("midreset_lit", lit, 672);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
